// File: rtl/fpu_pkg.sv
// Shared FPU definitions: single-precision field widths, special encodings,
// divider FSM states and the operand classifier.
package fpu_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 2**(EXP_W-1) - 1;
    localparam int QB    = MAN_W + 3;

    localparam logic [EXP_W-1:0] EXP_INF  = '1;
    localparam logic [MAN_W-1:0] NAN_FRAC = MAN_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIVIDE,
        ST_NORM,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } fp_class_t;

    // Denormals are treated as zero: only the exponent field decides zero-ness.
    function automatic fp_class_t fp_classify(input logic [EXP_W+MAN_W-1:0] a);
        fp_class_t c;
        c.is_zero = (a[EXP_W+MAN_W-1:MAN_W] == '0);
        c.is_inf  = (a[EXP_W+MAN_W-1:MAN_W] == EXP_INF) && (a[MAN_W-1:0] == '0);
        c.is_nan  = (a[EXP_W+MAN_W-1:MAN_W] == EXP_INF) && (a[MAN_W-1:0] != '0);
        return c;
    endfunction

endpackage

// File: rtl/mant_div_radix2.sv
// Radix-2 restoring mantissa divider: one quotient bit per clock, the first
// bit is produced on the start edge so QB bits take exactly QB edges.
module mant_div_radix2 #(
    parameter int MAN_W = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [MAN_W:0]   ma,
    input  logic [MAN_W:0]   mb,
    output logic [MAN_W+2:0] q,
    output logic             q_valid
);

    localparam int QB    = MAN_W + 3;
    localparam int CNT_W = $clog2(QB + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(QB - 1);

    logic [MAN_W+1:0] rem_q, rem_cur, rem_sub, rem_d;
    logic [MAN_W:0]   mb_q, div_cur;
    logic [QB-1:0]    q_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q, q_valid_q, q_bit;

    always_comb begin
        rem_cur = start ? {1'b0, ma} : rem_q;
        div_cur = start ? mb : mb_q;
        q_bit   = (rem_cur >= {1'b0, div_cur});
        rem_sub = q_bit ? (rem_cur - {1'b0, div_cur}) : rem_cur;
        // rem_sub < divisor, so the shift never loses a set bit
        rem_d   = rem_sub << 1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q     <= '0;
            mb_q      <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
            q_valid_q <= 1'b0;
        end else begin
            q_valid_q <= 1'b0;
            if (start) begin
                rem_q <= rem_d;
                mb_q  <= mb;
                q_q   <= {{(QB-1){1'b0}}, q_bit};
                cnt_q <= CNT_W'(1);
                run_q <= 1'b1;
            end else if (run_q) begin
                rem_q <= rem_d;
                q_q   <= {q_q[QB-2:0], q_bit};
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    run_q     <= 1'b0;
                    q_valid_q <= 1'b1;
                end
            end
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;

endmodule

// File: rtl/fpu_divider_seq.sv
// Sequential IEEE-754 single-precision divider Res = A / B with start/done
// handshake; specials bypass the iterative mantissa divider.
module fpu_divider_seq
    import fpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [EXP_W+MAN_W:0] A,
    input  logic [EXP_W+MAN_W:0] B,
    output logic [EXP_W+MAN_W:0] Res,
    output logic                 busy,
    output logic                 done
);

    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic signed [EXP_W+1:0] E_BIAS    = (EXP_W+2)'(BIAS);
    localparam logic signed [EXP_W+1:0] E_BIAS_M1 = (EXP_W+2)'(BIAS - 1);
    localparam logic signed [EXP_W+1:0] E_ONE     = (EXP_W+2)'(1);
    localparam logic signed [EXP_W+1:0] E_ZERO    = '0;
    localparam logic signed [EXP_W+1:0] E_MAX     = {2'b00, EXP_INF};

    state_e        state_q;
    logic [W-1:0]  a_q, b_q, res_q, res_d;
    logic          start_q, busy_q, done_q;
    logic          sign, is_special, div_start, q_valid;
    logic [QB-1:0] quo;
    fp_class_t     ca, cb;

    function automatic logic [W-1:0] special_res(input logic s, input fp_class_t xa,
                                                 input fp_class_t xb);
        if (xa.is_nan || xb.is_nan || (xa.is_zero && xb.is_zero) || (xa.is_inf && xb.is_inf))
            return {s, EXP_INF, NAN_FRAC};
        else if (xb.is_zero || xa.is_inf)
            return {s, EXP_INF, {MAN_W{1'b0}}};
        else
            return {s, {(EXP_W+MAN_W){1'b0}}};
    endfunction

    // Round-half-up on the guard bit; exponent kept 2 bits wider to catch over/underflow.
    function automatic logic [W-1:0] round_norm(input logic s, input logic [EXP_W-1:0] ea,
                                                input logic [EXP_W-1:0] eb, input logic [QB-1:0] qv);
        logic signed [EXP_W+1:0] e;
        logic [MAN_W:0]          m;
        e = $signed({2'b00, ea}) - $signed({2'b00, eb}) + (qv[QB-1] ? E_BIAS : E_BIAS_M1);
        m = qv[QB-1] ? ({1'b0, qv[QB-2:2]} + (MAN_W+1)'(qv[1]))
                     : ({1'b0, qv[QB-3:1]} + (MAN_W+1)'(qv[0]));
        if (m[MAN_W]) begin
            m = '0;
            e = e + E_ONE;
        end
        if (e >= E_MAX)
            return {s, EXP_INF, {MAN_W{1'b0}}};
        else if (e <= E_ZERO)
            return {s, {(EXP_W+MAN_W){1'b0}}};
        else
            return {s, e[EXP_W-1:0], m[MAN_W-1:0]};
    endfunction

    assign ca         = fp_classify(a_q[W-2:0]);
    assign cb         = fp_classify(b_q[W-2:0]);
    assign sign       = a_q[W-1] ^ b_q[W-1];
    assign is_special = (|ca) || (|cb);
    assign div_start  = start_q && !is_special;
    assign res_d      = is_special ? special_res(sign, ca, cb)
                                   : round_norm(sign, a_q[W-2:MAN_W], b_q[W-2:MAN_W], quo);

    mant_div_radix2 #(
        .MAN_W(MAN_W)
    ) u_mant_div (
        .clk     (clk),
        .reset   (reset),
        .start   (div_start),
        .ma      ({1'b1, a_q[MAN_W-1:0]}),
        .mb      ({1'b1, b_q[MAN_W-1:0]}),
        .q       (quo),
        .q_valid (q_valid)
    );

    // Operands are captured first; classification and dispatch happen one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_q) begin
                        state_q <= is_special ? ST_NORM : ST_DIVIDE;
                        busy_q  <= 1'b1;
                    end else if (enable) begin
                        a_q     <= A;
                        b_q     <= B;
                        start_q <= 1'b1;
                    end
                end
                ST_DIVIDE: begin
                    if (q_valid)
                        state_q <= ST_NORM;
                end
                ST_NORM: begin
                    res_q   <= res_d;
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    if (enable) begin
                        a_q     <= A;
                        b_q     <= B;
                        start_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Res  = res_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_fpu_divider_seq.sv
// Scoreboard bench for fpu_divider_seq: expected results and latencies are
// queued at issue and checked when done rises.
module tb_fpu_divider_seq;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [31:0] A, B, Res;
    logic        busy, done;

    fpu_divider_seq dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .A      (A),
        .B      (B),
        .Res    (Res),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    int          issue_q[$];
    int          lat_q[$];
    logic        done_prev = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Result/latency scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_done", 32'(done), 32'h0);
            end else begin
                check_val("res", Res, exp_q.pop_front());
                check_val("latency", 32'(cyc - issue_q.pop_front()), 32'(lat_q.pop_front()));
            end
        end
        done_prev <= done;
    end

    // Called at a falling edge; the next rising edge is edge 0.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] e, input int lat);
        A      = a;
        B      = b;
        enable = 1'b1;
        exp_q.push_back(e);
        issue_q.push_back(cyc + 1);
        lat_q.push_back(lat);
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check_val("timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
            issue_q.delete();
            lat_q.delete();
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[$] = '{
        '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28},
        '{32'hC1000000, 32'h3F000000, 32'hC1800000, 28},
        '{32'h7F000000, 32'h3F000000, 32'h7F800000, 28},
        '{32'h3F800000, 32'h00000000, 32'h7F800000, 2},
        '{32'h00000000, 32'h00000000, 32'h7F800001, 2},
        '{32'h00000000, 32'h40400000, 32'h00000000, 2},
        '{32'h7FC00000, 32'h3F800000, 32'h7F800001, 2},
        '{32'hBF800000, 32'h00000000, 32'hFF800000, 2},
        '{32'h7F800000, 32'h7F800000, 32'h7F800001, 2},
        '{32'h3F800000, 32'h7F800000, 32'h00000000, 2}
    };

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        A      = '0;
        B      = '0;
        repeat (2) @(negedge clk);
        check_val("rst_res", Res, 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_done", 32'(done), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // 6.0 / 2.0 with busy window observation
        start_op(32'h40C00000, 32'h40000000, 32'h40400000, 28);
        @(negedge clk);
        check_val("busy_e1", 32'(busy), 32'h1);
        repeat (26) @(negedge clk);
        check_val("busy_e27", 32'(busy), 32'h1);
        check_val("done_e27", 32'(done), 32'h0);
        @(negedge clk);
        check_val("busy_e28", 32'(busy), 32'h0);
        check_val("done_e28", 32'(done), 32'h1);
        wait_idle();

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat);
            wait_idle();
        end

        // enable while busy must be ignored
        start_op(32'h40C00000, 32'h40000000, 32'h40400000, 28);
        repeat (5) @(negedge clk);
        A      = 32'h3F800000;
        B      = 32'h40400000;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);
        check_val("ignored_res", Res, 32'h40400000);

        // enable sampled in DONE starts a new operation
        start_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28);
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        start_op(32'h40C00000, 32'h40000000, 32'h40400000, 28);
        check_val("done_drop", 32'(done), 32'h0);
        check_val("res_hold", Res, 32'h3EAAAAAB);
        wait_idle();

        // asynchronous reset mid-division
        start_op(32'h40C00000, 32'h40000000, 32'h40400000, 28);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("abort_res", Res, 32'h0);
        check_val("abort_busy", 32'(busy), 32'h0);
        check_val("abort_done", 32'(done), 32'h0);
        exp_q.delete();
        issue_q.delete();
        lat_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
